// File: rtl/pick_cards_if.sv
// Player/consumer bus for the three-card picker: key and switch inputs, packed picks and status out.
interface pick_cards_if;
    logic        start;
    logic [3:0]  card_in;
    logic        select;
    logic        undo;
    logic        ack;
    logic [11:0] data_out;
    logic        valid;
    logic [1:0]  count;
    logic        error;
    logic        busy;

    modport master (
        output start, card_in, select, undo, ack,
        input  data_out, valid, count, error, busy
    );

    modport slave (
        input  start, card_in, select, undo, ack,
        output data_out, valid, count, error, busy
    );
endinterface

// File: rtl/pick_cards.sv
// Three distinct-card picker with undo; key edges take effect one cycle later on registered outputs.
// Picks are held in HOLD until ack; there is no other backpressure.
module pick_cards #(
    parameter int unsigned MAX_CARD = 9
) (
    input  logic       clk,
    input  logic       reset,
    pick_cards_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PICK, HOLD} state_t;

    state_t      state, state_nxt;
    logic [11:0] data_q, data_nxt;
    logic [1:0]  count_q, count_nxt;
    logic        valid_q, valid_nxt;
    logic        error_q, error_nxt;
    logic        busy_q, busy_nxt;
    logic        select_q, undo_q;
    logic        select_edge, undo_edge;
    logic        card_dup, card_legal;

    assign select_edge = bus.select & ~select_q;
    assign undo_edge   = bus.undo & ~undo_q;

    // Only occupied slots (index below count) take part in the duplicate check.
    always_comb begin
        card_dup = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if ((2'(i) < count_q) && (data_q[i*4 +: 4] == bus.card_in)) begin
                card_dup = 1'b1;
            end
        end
        card_legal = (bus.card_in != 4'd0) && ({28'd0, bus.card_in} <= MAX_CARD) && !card_dup;
    end

    always_comb begin
        state_nxt = state;
        data_nxt  = data_q;
        count_nxt = count_q;
        valid_nxt = valid_q;
        busy_nxt  = busy_q;
        error_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = PICK;
                    data_nxt  = '0;
                    count_nxt = '0;
                    valid_nxt = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            PICK: begin
                // Undo wins over a simultaneous select edge.
                if (undo_edge) begin
                    if (count_q != 2'd0) begin
                        count_nxt = count_q - 2'd1;
                        data_nxt[{count_nxt, 2'b00} +: 4] = 4'd0;
                    end else begin
                        error_nxt = 1'b1;
                    end
                end else if (select_edge) begin
                    if (card_legal) begin
                        data_nxt[{count_q, 2'b00} +: 4] = bus.card_in;
                        count_nxt = count_q + 2'd1;
                        if (count_q == 2'd2) begin
                            state_nxt = HOLD;
                            valid_nxt = 1'b1;
                        end
                    end else begin
                        error_nxt = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.ack) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                    count_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            data_q   <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            busy_q   <= 1'b0;
            select_q <= 1'b0;
            undo_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            data_q   <= data_nxt;
            count_q  <= count_nxt;
            valid_q  <= valid_nxt;
            error_q  <= error_nxt;
            busy_q   <= busy_nxt;
            select_q <= bus.select;
            undo_q   <= bus.undo;
        end
    end

    assign bus.data_out = data_q;
    assign bus.count    = count_q;
    assign bus.valid    = valid_q;
    assign bus.error    = error_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_pick_cards.sv
// Randomised and directed stimulus against a queue-based reference model; a monitor checks every cycle.
module tb_pick_cards;
    localparam int MAXC = 9;

    logic clk = 1'b0;
    logic reset;
    pick_cards_if bus ();

    pick_cards #(.MAX_CARD(MAXC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] data;
        logic        valid;
        logic [1:0]  count;
        logic        error;
        logic        busy;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: mode 0 idle, 1 picking, 2 holding; picks kept as a plain list.
    int   mode = 0;
    int   picks[$];
    logic [11:0] idle_data = '0;
    bit   m_sel_prev = 0, m_undo_prev = 0, m_err = 0;

    function automatic logic [11:0] packed_picks();
        logic [11:0] d = '0;
        foreach (picks[i]) d = d | (12'(picks[i]) << (4 * i));
        return d;
    endfunction

    task automatic model_step(input bit rst, input bit st, input int card,
                              input bit sel, input bit und, input bit ak);
        bit se, ue, legal;
        se = sel && !m_sel_prev;
        ue = und && !m_undo_prev;
        m_err = 0;
        if (rst) begin
            mode = 0;
            picks.delete();
            idle_data = '0;
            m_sel_prev = 0;
            m_undo_prev = 0;
        end else begin
            m_sel_prev = sel;
            m_undo_prev = und;
            if (mode == 0) begin
                if (st) begin
                    mode = 1;
                    picks.delete();
                end
            end else if (mode == 1) begin
                if (ue) begin
                    if (picks.size() > 0) void'(picks.pop_back());
                    else m_err = 1;
                end else if (se) begin
                    legal = (card >= 1) && (card <= MAXC);
                    foreach (picks[i]) if (picks[i] == card) legal = 0;
                    if (legal) begin
                        picks.push_back(card);
                        if (picks.size() == 3) mode = 2;
                    end else begin
                        m_err = 1;
                    end
                end
            end else begin
                if (ak) begin
                    idle_data = packed_picks();
                    mode = 0;
                end
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.data  = (mode == 0) ? idle_data : packed_picks();
        e.valid = (mode == 2);
        e.count = (mode == 0) ? 2'd0 : 2'(picks.size());
        e.error = m_err;
        e.busy  = (mode != 0);
        return e;
    endfunction

    task automatic drive(input bit rst, input bit st, input logic [3:0] card,
                         input bit sel, input bit und, input bit ak);
        @(negedge clk);
        reset       = rst;
        bus.start   = st;
        bus.card_in = card;
        bus.select  = sel;
        bus.undo    = und;
        bus.ack     = ak;
        model_step(rst, st, int'(card), sel, und, ak);
        sb.push_back(model_out());
    endtask

    task automatic press(input logic [3:0] card);
        drive(0, 0, card, 1, 0, 0);
        drive(0, 0, card, 0, 0, 0);
    endtask

    task automatic press_undo();
        drive(0, 0, 4'd0, 0, 1, 0);
        drive(0, 0, 4'd0, 0, 0, 0);
    endtask

    // Monitor: outputs are registered, so each sample after a rising edge answers the last drive.
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a = {bus.data_out, bus.valid, bus.count, bus.error, bus.busy};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL outputs t=%0t: got data=%h valid=%b count=%0d error=%b busy=%b, need data=%h valid=%b count=%0d error=%b busy=%b",
                             $time, a.data, a.valid, a.count, a.error, a.busy,
                             e.data, e.valid, e.count, e.error, e.busy);
                end
            end
        end
    end

    initial begin
        bit sel_r, und_r;
        logic [3:0] card_r;
        reset = 1'b1;
        bus.start = 0; bus.card_in = 0; bus.select = 0; bus.undo = 0; bus.ack = 0;

        // Basic run 1,5,9 then ack; data must survive in IDLE.
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 1, 1, 1);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        press(1); press(5); press(9);
        drive(0, 1, 2, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 3, 1, 0, 0);

        // Duplicate rejection then another accept.
        drive(0, 1, 0, 0, 0, 0);
        press(4); press(4); press(7);

        // Illegal codes 0 and 10 in a fresh run.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        press(0); press(10); press(15);

        // Undo behaviour, including undo at count 0.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        press_undo();
        press(2); press(3); press_undo(); press(6); press(8);
        press_undo();
        drive(0, 0, 0, 0, 0, 1);

        // Held select counts once; simultaneous select+undo acts as undo.
        drive(0, 1, 0, 0, 0, 0);
        repeat (5) drive(0, 0, 3, 1, 0, 0);
        drive(0, 0, 3, 0, 0, 0);
        drive(0, 0, 5, 1, 1, 0);
        drive(0, 0, 5, 0, 0, 0);

        // Key held across start gives no edge.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 4, 1, 0, 0);
        drive(0, 0, 4, 1, 0, 0);
        drive(0, 0, 4, 0, 0, 0);

        // Reset mid-run, then select without start.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        press(1); press(2);
        drive(1, 0, 0, 0, 0, 0);
        press(3);

        // Random phase.
        sel_r = 0; und_r = 0;
        for (int n = 0; n < 4000; n++) begin
            card_r = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                 : 4'($urandom_range(1, MAXC));
            if ($urandom_range(0, 2) == 0) sel_r = ~sel_r;
            if ($urandom_range(0, 7) == 0) und_r = ~und_r;
            drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0), card_r,
                  sel_r, und_r, ($urandom_range(0, 3) == 0));
        end

        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected entries left, need 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
